pulse_meter: RTL and testbench
==============================

# pulse_meter

Synthesizable measurement stage that sits directly downstream of the pulse generators in the Guia 09 clock/pulse exercises. It samples one pulse waveform on the shared `clock` over a fixed window. It reports the rising-edge count, total high time and longest high run, all in clock cycles. The block turns the generator outputs (p1..p4) into numbers a bench can check, replacing manual waveform inspection.

## Interface
- `WIDTH`, 8: width of every result counter (edges, high_total, high_max).
- `WINDOW`, 48: measurement window length in clock cycles; legal range is 2..65535.
- `clock`  input  1  single system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `signal`  input  1  pulse waveform under measurement; may be asynchronous to `clock`.
- `start`  input  1  request a measurement; sampled only in IDLE.
- `busy`  output  1  high during every MEASURE cycle.
- `done`  output  1  one-cycle pulse when results update.
- `edges`  output  WIDTH  rising edges seen in the last completed window.
- `high_total`  output  WIDTH  cycles `signal` was high in the last completed window.
- `high_max`  output  WIDTH  longest continuous high run in the last completed window.

## Operation
- Input path: 3-stage shift register s1 <= signal, s2 <= s1, s3 <= s2.
  - s2 is the synchronized sample.
  - rise = s2 & ~s3.
  - Synchronizer registers run in every state, including IDLE.
- FSM states are IDLE, MEASURE and DONE.
  - IDLE: if start = 1, clear the working counters (edge_cnt, tot_cnt, run_cnt, max_cnt, win_cnt) and go to MEASURE.
  - MEASURE: lasts exactly WINDOW cycles, tracked by win_cnt 0..WINDOW-1. On the cycle where win_cnt = WINDOW-1, go to DONE.
  - DONE: one cycle, then go to IDLE.
- In each MEASURE cycle, evaluate using that cycle's s2 and s3:
  - rise = 1: edge_cnt += 1.
  - s2 = 1: tot_cnt += 1 and run_cnt += 1; max_cnt = max(max_cnt, run_cnt+1).
  - s2 = 0: run_cnt = 0.
- A rise on the first MEASURE cycle counts when s3 = 0, even if that low level was sampled before the window.
- A high run still in progress at window end is included in high_max.
- Arithmetic: all working counters saturate at 2^WIDTH-1 and never wrap. run_cnt saturates the same way.
- On the last MEASURE cycle, register the final values of edge_cnt, tot_cnt and max_cnt, including that cycle's contribution, into edges, high_total and high_max.
- Outputs then hold until the next completed window or reset.
- `start` is ignored in MEASURE and DONE, with no queuing. A held `start` re-triggers on the first IDLE cycle after DONE.

## Timing
- Reset values: busy = 0, done = 0, edges = 0, high_total = 0, high_max = 0. State = IDLE; s1/s2/s3 and all working counters = 0.
- Reset has priority over every other event, including mid-MEASURE and in DONE.
  - A reset mid-window discards partial counts.
  - A reset mid-window also clears the previously held results to 0.
- Input latency: a level change on `signal` reaches s2 two rising edges later.
- Start latency:
  - start is sampled high in IDLE at edge N.
  - MEASURE cycles are edges N+1 .. N+WINDOW, with busy = 1 during those cycles.
- Completion:
  - done = 1 and the new results are visible in the cycle after edge N+WINDOW, which is the DONE state.
  - busy = 0 in DONE.
  - Results are stable from that cycle on.
- Back-to-back: with start held high, the earliest next MEASURE begins 2 cycles after the previous window's last MEASURE cycle (DONE, then IDLE sampling start).
- Throughput: one window every WINDOW+2 cycles.

## Test plan
- Reset then idle: hold reset 3 cycles, release with signal = 0 and start = 0 → all outputs 0 and busy = 0 for 100 cycles.
- Constant high, default parameters: signal = 1 for 10 cycles before start → after the window, edges = 0, high_total = 48, high_max = 48; done high exactly 1 cycle, 49 cycles after the start edge.
- Square wave, 4 high / 4 low, aligned so s2 first rises on the first MEASURE cycle with s3 = 0 → edges = 6, high_total = 24, high_max = 4.
- Saturation: WIDTH = 4, WINDOW = 48, constant high → high_total = 15, high_max = 15, edges = 0; values must not wrap to 0.
- Start ignored while busy: pulse start again at window cycle 10 → exactly one done pulse, at cycle 49; busy stays high for exactly 48 cycles.
- Reset mid-operation: run the square-wave case to completion, start a second window, assert reset at window cycle 20 → next cycle all outputs 0, busy = 0, no done pulse; a new start then gives edges = 6 again.

Source files
------------

// File: rtl/pulse_meter.sv
// Measures rising-edge count, total high time and longest high run of one
// pulse waveform over a fixed window of WINDOW clock cycles.
module pulse_meter #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] edges,
    output logic [WIDTH-1:0] high_total,
    output logic [WIDTH-1:0] high_max
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_s1, r_s2, r_s3;
    logic [WIDTH-1:0] r_edge_cnt, r_tot_cnt, r_run_cnt, r_max_cnt;
    logic [15:0]      r_win_cnt;
    logic             w_rise;
    logic             w_last;
    logic [WIDTH-1:0] w_edge_next, w_tot_next, w_run_next, w_max_next;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_rise = r_s2 & ~r_s3;
    assign w_last = (r_state == ST_MEASURE) && (r_win_cnt == WIN_LAST);

    // s2 is the synchronized sample; s3 is its previous value for edge detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= signal;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // This cycle's contribution; also feeds the result registers on the last cycle.
    always_comb begin
        w_edge_next = w_rise ? sat_inc(r_edge_cnt) : r_edge_cnt;
        w_tot_next  = r_s2 ? sat_inc(r_tot_cnt) : r_tot_cnt;
        w_run_next  = r_s2 ? sat_inc(r_run_cnt) : '0;
        w_max_next  = (r_s2 && (w_run_next > r_max_cnt)) ? w_run_next : r_max_cnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_edge_cnt <= '0;
            r_tot_cnt  <= '0;
            r_run_cnt  <= '0;
            r_max_cnt  <= '0;
            r_win_cnt  <= '0;
            edges      <= '0;
            high_total <= '0;
            high_max   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_edge_cnt <= '0;
                        r_tot_cnt  <= '0;
                        r_run_cnt  <= '0;
                        r_max_cnt  <= '0;
                        r_win_cnt  <= '0;
                    end
                end
                ST_MEASURE: begin
                    r_edge_cnt <= w_edge_next;
                    r_tot_cnt  <= w_tot_next;
                    r_run_cnt  <= w_run_next;
                    r_max_cnt  <= w_max_next;
                    r_win_cnt  <= r_win_cnt + 16'd1;
                    if (w_last) begin
                        edges      <= w_edge_next;
                        high_total <= w_tot_next;
                        high_max   <= w_max_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: constant-high, square-wave, saturation,
// start-while-busy and mid-window reset scenarios with hand-computed results.
module tb_pulse_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal;
    logic       start;
    logic       busy, done;
    logic [7:0] edges, high_total, high_max;
    logic       busy4, done4;
    logic [3:0] edges4, high_total4, high_max4;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;   // 0: low, 1: high, 2: square 4 high / 4 low
    int phase = 0;

    always #5 clk = ~clk;

    pulse_meter #(.WIDTH(8), .WINDOW(48)) dut (
        .clock(clk), .reset(reset), .signal(signal), .start(start),
        .busy(busy), .done(done), .edges(edges),
        .high_total(high_total), .high_max(high_max)
    );

    pulse_meter #(.WIDTH(4), .WINDOW(48)) dut4 (
        .clock(clk), .reset(reset), .signal(signal), .start(start),
        .busy(busy4), .done(done4), .edges(edges4),
        .high_total(high_total4), .high_max(high_max4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        signal = (mode == 1) || ((mode == 2) && (phase < 4));
        @(posedge clk);
        #1;
        phase = (phase + 1) % 8;
    endtask

    // Cycle 1 is the sample right after the edge that takes start.
    task automatic measure(input int again, output int busy_cnt, output int done_cnt,
                           output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 60; i++) begin
            start = (i == 1) || (i == again);
            step();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        start = 1'b0;
    endtask

    task automatic align_square();
        mode = 0;
        repeat (4) step();
        mode  = 2;
        phase = 0;
        step();
    endtask

    int bc, dc, da, dcount;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        signal = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_edges", edges, 0);
        check("rst_total", high_total, 0);
        check("rst_max", high_max, 0);
        reset = 1'b0;

        dcount = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy || done || (|edges) || (|high_total) || (|high_max)) dcount++;
        end
        check("idle_quiet_cycles", dcount, 0);

        // Constant high, level already established before the window.
        mode = 1;
        repeat (10) step();
        measure(0, bc, dc, da);
        check("hi_busy_cycles", bc, 48);
        check("hi_done_count", dc, 1);
        check("hi_done_at", da, 49);
        check("hi_edges", edges, 0);
        check("hi_total", high_total, 48);
        check("hi_max", high_max, 48);
        check("sat_edges", edges4, 0);
        check("sat_total", high_total4, 15);
        check("sat_max", high_max4, 15);

        // Square wave, s2 rises on the first measure cycle.
        align_square();
        measure(0, bc, dc, da);
        check("sq_done_at", da, 49);
        check("sq_edges", edges, 6);
        check("sq_total", high_total, 24);
        check("sq_max", high_max, 4);
        check("sq4_total", high_total4, 15);
        check("sq4_max", high_max4, 4);

        // Second start pulse in the middle of the window is ignored.
        align_square();
        measure(10, bc, dc, da);
        check("ign_busy_cycles", bc, 48);
        check("ign_done_count", dc, 1);
        check("ign_done_at", da, 49);
        check("ign_edges", edges, 6);

        // Reset at window cycle 20 clears everything.
        align_square();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_edges", edges, 0);
        check("mid_total", high_total, 0);
        check("mid_max", high_max, 0);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done || busy) dcount++;
        end
        check("mid_no_activity", dcount, 0);
        align_square();
        measure(0, bc, dc, da);
        check("post_done_count", dc, 1);
        check("post_edges", edges, 6);
        check("post_total", high_total, 24);
        check("post_max", high_max, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
